// File: rtl/secuenciador_multiciclo_pkg.sv
// Shared definitions for the multi-cycle sequencer: opcodes, ALU operation classes,
// FSM state encoding and the branch-offset helper.
package secuenciador_multiciclo_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT,
        ST_ERROR
    } sec_state_t;

    // Word offset of a branch: sign-extended immediate scaled by 4.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/secuenciador_multiciclo_contador_espera.sv
// Wait counter shared by the FETCH and MEM handshakes; limite flags the last
// cycle a request may still be acknowledged before timing out.
module contador_espera #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic limite
);

    localparam logic [CNT_W-1:0] UNO       = 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + UNO;
        end
    end

    assign limite = (cnt == CNT_LIMIT);

endmodule

// File: rtl/secuenciador_multiciclo.sv
// Multi-cycle control FSM: fetch over req/ack, decode, and per-phase datapath enables.
// Optional SEC_CONTADORES_EN adds the ciclos / retiradas performance counters.
module secuenciador_multiciclo
    import secuenciador_multiciclo_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          TIMEOUT  = 16,
    parameter int          CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        dmem_req,
    input  logic        dmem_ack,
    output logic [31:0] TR,
    input  logic        alu_zf,
    output logic        RegWrite,
    output logic        MemToWrite,
    output logic        MemToRg,
    output logic [1:0]  ALUOP,
    output logic [31:0] pc,
    output logic        halted,
    output logic        error,
    output sec_state_t  state_dbg
`ifdef SEC_CONTADORES_EN
    ,
    output logic [31:0] ciclos,
    output logic [31:0] retiradas
`endif
);

    // Handshake: a req stays high with a stable address until its ack; an ack
    // is consumed only in a cycle where the matching req is high, otherwise ignored.

    sec_state_t  state, state_next;
    logic [31:0] pc_r, tr_r;
    logic [5:0]  opcode;
    logic        imem_fire, dmem_fire;
    logic        espera_en, espera_clr, espera_limite;

    assign opcode    = tr_r[31:26];
    assign imem_fire = (state == ST_FETCH) && imem_ack;
    assign dmem_fire = (state == ST_MEM) && dmem_ack;
    assign espera_en  = (state == ST_FETCH) || (state == ST_MEM);
    assign espera_clr = !espera_en || imem_fire || dmem_fire;

    contador_espera #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_espera (
        .clk    (clk),
        .rst    (rst),
        .clr    (espera_clr),
        .en     (espera_en),
        .limite (espera_limite)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_FETCH;
            // An ack in the final allowed cycle still wins over the timeout.
            ST_FETCH: begin
                if (imem_ack)           state_next = ST_DECODE;
                else if (espera_limite) state_next = ST_ERROR;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ: state_next = ST_EXEC;
                    OP_HALT:                        state_next = ST_HALT;
                    default:                        state_next = ST_ERROR;
                endcase
            end
            ST_EXEC: begin
                case (opcode)
                    OP_RTYPE:     state_next = ST_WB;
                    OP_LW, OP_SW: state_next = ST_MEM;
                    OP_BEQ:       state_next = ST_FETCH;
                    default:      state_next = ST_ERROR;
                endcase
            end
            ST_MEM: begin
                if (dmem_ack)           state_next = (opcode == OP_SW) ? ST_FETCH : ST_WB;
                else if (espera_limite) state_next = ST_ERROR;
            end
            ST_WB:     state_next = ST_FETCH;
            ST_HALT:   state_next = ST_HALT;
            ST_ERROR:  state_next = ST_ERROR;
            default:   state_next = ST_ERROR;
        endcase
    end

    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        RegWrite   = 1'b0;
        MemToWrite = 1'b0;
        MemToRg    = 1'b0;
        ALUOP      = ALUOP_ADD;
        case (state)
            ST_FETCH: imem_req = 1'b1;
            ST_EXEC: begin
                case (opcode)
                    OP_RTYPE: ALUOP = ALUOP_FUNCT;
                    OP_BEQ:   ALUOP = ALUOP_SUB;
                    default:  ALUOP = ALUOP_ADD;
                endcase
            end
            ST_MEM: begin
                dmem_req   = 1'b1;
                MemToWrite = (opcode == OP_SW);
            end
            ST_WB: begin
                RegWrite = 1'b1;
                MemToRg  = (opcode == OP_LW);
            end
            default: ;
        endcase
    end

    // pc already points past the branch when EXEC adds the offset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= PC_RESET;
            tr_r <= '0;
        end else if (imem_fire) begin
            tr_r <= imem_data;
            pc_r <= pc_r + 32'd4;
        end else if ((state == ST_EXEC) && (opcode == OP_BEQ) && alu_zf) begin
            pc_r <= pc_r + branch_offset(tr_r[15:0]);
        end
    end

    assign imem_addr = pc_r;
    assign pc        = pc_r;
    assign TR        = tr_r;
    assign halted    = (state == ST_HALT);
    assign error     = (state == ST_ERROR);
    assign state_dbg = state;

`ifdef SEC_CONTADORES_EN
    logic activo, retira;

    assign activo = (state != ST_IDLE) && (state != ST_HALT) && (state != ST_ERROR);
    assign retira = (state == ST_WB)
                 || ((state == ST_MEM) && dmem_ack && (opcode == OP_SW))
                 || ((state == ST_EXEC) && (opcode == OP_BEQ));

    always_ff @(posedge clk) begin
        if (rst) begin
            ciclos    <= '0;
            retiradas <= '0;
        end else begin
            if (activo) ciclos    <= ciclos + 32'd1;
            if (retira) retiradas <= retiradas + 32'd1;
        end
    end
`endif

endmodule

// File: doc/secuenciador_multiciclo.md
Name: secuenciador_multiciclo

Overview:
Multi-cycle control FSM that sequences the shared register-bank/ALU/RAM datapath one instruction at a time. Owns PC and the instruction register (TR), fetches over a req/ack handshake, decodes TR[31:26], and drives the per-phase enables: reg write, mem write, mem-to-reg select, ALU op class. Replaces the always-asserted single-cycle controls so the datapath can stall on slow memories.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset.
TIMEOUT, 16, max cycles waiting for any ack before ERROR; legal range 2..255.
CNT_W, 8, width of the internal wait counter; must hold TIMEOUT.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous reset, active high.
start  in  1  level; leaves IDLE when 1.
imem_req  out  1  instruction fetch request.
imem_ack  in  1  fetch data valid this cycle.
imem_addr  out  32  fetch address (= PC).
imem_data  in  32  fetched instruction.
dmem_req  out  1  data-memory access request.
dmem_ack  in  1  data access complete this cycle.
TR  out  32  instruction register to datapath.
alu_zf  in  1  ALU zero flag.
RegWrite  out  1  register-bank write enable, one-cycle pulse.
MemToWrite  out  1  data-memory write (valid with dmem_req).
MemToRg  out  1  write-back source: 1 = memory, 0 = ALU.
ALUOP  out  2  00 add, 01 sub, 10 use funct, 11 reserved.
pc  out  32  current PC.
halted  out  1  1 in HALT.
error  out  1  1 in ERROR (timeout or illegal opcode).

Behaviour:
- Reset (synchronous, dominant in every state): state=IDLE, pc=PC_RESET, TR=0, all request/enable outputs 0, ALUOP=00, MemToRg=0, halted=0, error=0, wait counter=0.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR.
- IDLE: outputs quiet; start=1 -> FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc held stable until ack. On imem_ack: TR<=imem_data, pc<=pc+4 (mod 2^32), counter cleared -> DECODE. If counter reaches TIMEOUT with no ack -> ERROR.
- DECODE (1 cycle): TR[31:26]: 000000 R-type, 100011 lw, 101011 sw, 000100 beq, 111111 halt, other -> ERROR.
- EXEC (1 cycle): ALUOP = 10 R-type, 00 lw/sw, 01 beq. R-type -> WB; lw/sw -> MEM; beq: if alu_zf=1, pc<=pc+(sext(TR[15:0])<<2), wrap mod 2^32; -> FETCH.
- MEM: dmem_req=1, MemToWrite=1 only for sw, ALUOP held at 00. On dmem_ack: sw -> FETCH, lw -> WB. Timeout as in FETCH -> ERROR.
- WB (1 cycle): RegWrite=1 exactly one cycle; MemToRg=1 for lw, 0 for R-type -> FETCH.
- halt opcode -> HALT; HALT and ERROR are sticky until rst. start ignored outside IDLE.
- Ack arriving in a cycle where the matching req is 0 is ignored. Ack on the same cycle the counter hits TIMEOUT: the ack wins.
- Latency per instruction with zero-wait ack: R-type 4, lw 5, sw 4, beq 3 cycles (FETCH..last state inclusive).
- TR changes only on an accepted fetch; stable through DECODE..WB.

Optional Feature:
SEC_CONTADORES_EN: when defined, adds outputs ciclos[31:0] (increments every cycle outside IDLE/HALT/ERROR) and retiradas[31:0] (increments on every completed instruction: WB exit, sw MEM exit, beq EXEC exit). Both reset to 0 and wrap. When undefined, the ports and logic are absent and the behaviour is otherwise identical.

Decomposition:
- Shared package: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_HALT), ALUOP encodings, state encoding.
- One sub-module: contador_espera (CNT_W-bit wait counter with clear, enable, and TIMEOUT-reached flag), instantiated once and shared by FETCH and MEM.

Test Plan:
- Reset mid-MEM (dmem_req=1) -> next cycle state IDLE, pc=0, all enables 0, dmem_req=0.
- R-type 0x00221820 with ack delayed 3 cycles -> TR loaded on ack, ALUOP=10 in EXEC, single RegWrite pulse, MemToRg=0, pc=4.
- lw 0x8C410008 then sw 0xAC410008, zero-wait acks -> lw 5 cycles, MemToRg=1 in WB; sw MemToWrite=1 with dmem_req and no RegWrite.
- beq at pc=0x10, imm=0xFFFE, alu_zf=1 -> pc=0x0C; with alu_zf=0 -> pc=0x14.
- imem_ack withheld, TIMEOUT=16 -> error=1 after 16 FETCH cycles, stays 1 until rst; ack on the 16th cycle -> accepted, no error.
- Opcode 0x3F -> halted=1, no further imem_req. Opcode 0x02 -> error=1. With SEC_CONTADORES_EN, retiradas matches the retired count.
